// File: rtl/dds_phase_accum.sv
// DDS phase accumulator / quarter-wave address generator.
// FTW updates arrive through a one-deep valid/ready slot. They are applied at
// accumulator wrap (phase-continuous), on any idle cycle, or on sync_clr.
// Stage 1 registers the offset phase of the current accumulator value.
// Stage 2 splits that phase into quadrant flags, a mirrored table address and
// the interpolation residue.
module dds_phase_accum #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 11,
  parameter int FRAC_W = ACC_W - ADDR_W - 2
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              en,
  input  logic              sync_clr,
  input  logic [ACC_W-1:0]  ftw_data,
  input  logic              ftw_valid,
  output logic              ftw_ready,
  input  logic [ACC_W-1:0]  pow_data,
  input  logic              pow_load,
  output logic [ADDR_W-1:0] Address,
  output logic              out1,
  output logic              out2,
  output logic [FRAC_W-1:0] frac,
  output logic              out_valid,
  output logic              wrap
);

  logic [ACC_W-1:0]  acc, ftw_active, pow_active, pend, phase;
  logic              pend_full, v1, c1;
  logic [ACC_W:0]    sum;
  logic              carry, take, apply, full_nxt;
  logic [ADDR_W-1:0] raw;
  logic              mir;

  // The increment that carries out still uses the old ftw_active, so the
  // carry is taken from the sum built with the current active word.
  assign sum      = {1'b0, acc} + {1'b0, ftw_active};
  assign carry    = en & ~sync_clr & sum[ACC_W];
  assign take     = ftw_valid & ftw_ready;
  assign apply    = pend_full & (~en | sync_clr | sum[ACC_W]);
  assign full_nxt = take | (pend_full & ~apply);

  assign raw = phase[ACC_W-3 -: ADDR_W];
  assign mir = phase[ACC_W-2];

  // Pending FTW slot. Ready is registered so it reads 0 throughout reset.
  // A word can only be captured while the slot is empty, so capture and
  // application never involve the same word in one cycle.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      pend       <= '0;
      pend_full  <= 1'b0;
      ftw_active <= '0;
      ftw_ready  <= 1'b0;
    end else begin
      if (take) pend <= ftw_data;
      if (apply) ftw_active <= pend;
      pend_full <= full_nxt;
      ftw_ready <= ~full_nxt;
    end
  end

  // Accumulator: clear has priority over advance. Otherwise the value holds.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) acc <= '0;
    else if (sync_clr) acc <= '0;
    else if (en) acc <= sum[ACC_W-1:0];
  end

  // Phase offset register. It is not handshaked and takes effect on the next sample.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) pow_active <= '0;
    else if (pow_load) pow_active <= pow_data;
  end

  // Stage 1: offset phase of the current accumulator value, tagged valid/carry.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      phase <= '0;
      v1    <= 1'b0;
      c1    <= 1'b0;
    end else begin
      phase <= acc + pow_active;
      v1    <= en & ~sync_clr;
      c1    <= carry;
    end
  end

  // Stage 2: quadrant split with a quarter-wave mirror on odd quadrants.
  // The data outputs hold across invalid samples.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      Address   <= '0;
      out1      <= 1'b0;
      out2      <= 1'b0;
      frac      <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      out_valid <= v1;
      wrap      <= c1 & v1;
      if (v1) begin
        out1    <= phase[ACC_W-1];
        out2    <= mir;
        Address <= mir ? ~raw : raw;
        frac    <= mir ? ~phase[FRAC_W-1:0] : phase[FRAC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Bench for dds_phase_accum. A cycle-level reference model pushes the expected
// phase/wrap of each sample into a queue. A negedge process pops one entry per
// out_valid and checks it. Each scenario task adds its own directed checks.
module tb_dds_phase_accum;

  logic        Fg_CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        en = 1'b0, sync_clr = 1'b0, ftw_valid = 1'b0, pow_load = 1'b0;
  logic [31:0] ftw_data = '0, pow_data = '0;
  logic        ftw_ready, out1, out2, out_valid, wrap;
  logic [10:0] Address;
  logic [18:0] frac;

  int nerr = 0;
  int nchk = 0;

  always #5 Fg_CLK = ~Fg_CLK;

  dds_phase_accum dut (
    .Fg_CLK(Fg_CLK), .RESETn(RESETn), .en(en), .sync_clr(sync_clr),
    .ftw_data(ftw_data), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready),
    .pow_data(pow_data), .pow_load(pow_load), .Address(Address),
    .out1(out1), .out2(out2), .frac(frac), .out_valid(out_valid), .wrap(wrap)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_acc = '0, m_ftw = '0, m_pend = '0, m_pow = '0;
  logic        m_pfull = 1'b0, m_ready = 1'b0;
  logic [32:0] sbq[$];
  logic [32:0] m_sum;
  logic        m_take, m_apply;

  assign m_sum   = {1'b0, m_acc} + {1'b0, m_ftw};
  assign m_take  = ftw_valid & m_ready;
  assign m_apply = m_pfull & (!en | sync_clr | m_sum[32]);

  // Model state follows the behaviour description. Each enabled sample is queued as {carry, phase}.
  always @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_acc <= '0; m_ftw <= '0; m_pend <= '0; m_pow <= '0;
      m_pfull <= 1'b0; m_ready <= 1'b0;
      sbq.delete();
    end else begin
      if (m_take) m_pend <= ftw_data;
      if (m_apply) m_ftw <= m_pend;
      m_pfull <= m_take || (m_pfull && !m_apply);
      m_ready <= !(m_take || (m_pfull && !m_apply));
      if (sync_clr) m_acc <= '0;
      else if (en) m_acc <= m_sum[31:0];
      if (pow_load) m_pow <= pow_data;
      if (en && !sync_clr) sbq.push_back({m_sum[32] & !sync_clr, m_acc + m_pow});
    end
  end

  // Expected {Address, out1, out2, frac, wrap} for a queued {carry, phase}.
  function automatic logic [32:0] exp_of(input logic [32:0] e);
    logic [10:0] raw, a;
    logic [18:0] f;
    raw = e[29:19];
    a = e[30] ? 11'(2047 - int'(raw)) : raw;
    f = e[30] ? 19'(524287 - int'(e[18:0])) : e[18:0];
    return {a, e[31], e[30], f, e[32]};
  endfunction

  // Scoreboard: compare the ready flag every cycle and pop one entry per valid sample.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge Fg_CLK);
      if (RESETn) begin
        nchk++;
        if (ftw_ready !== m_ready) begin
          nerr++;
          $display("FAIL sb_ready got=%b exp=%b t=%0t", ftw_ready, m_ready, $time);
        end
        if (out_valid === 1'b1) begin
          nchk++;
          if (sbq.size() == 0) begin
            nerr++;
            $display("FAIL sb_unexpected_valid got=1 exp=0 t=%0t", $time);
          end else begin
            e = exp_of(sbq.pop_front());
            if ({Address, out1, out2, frac, wrap} !== e) begin
              nerr++;
              $display("FAIL sb_sample got=%h exp=%h t=%0t",
                       {Address, out1, out2, frac, wrap}, e, $time);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(negedge Fg_CLK);
  endtask

  // Handshake a word with en low so that it is applied on the following idle cycle.
  task automatic load_ftw(input logic [31:0] w);
    en = 1'b0;
    ftw_data = w; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string nm);
    en = 1'b0;
    repeat (3) tick();
    nchk++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL %s got=%0d exp=0 (samples left)", nm, sbq.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    RESETn = 1'b0;
    repeat (2) tick();
    nchk++;
    if ({Address, out1, out2, frac, out_valid, wrap, ftw_ready} !== 35'd0) begin
      nerr++;
      $display("FAIL reset_outputs got=%h exp=0", {Address, out1, out2, frac, out_valid, wrap, ftw_ready});
    end
    RESETn = 1'b1;
    tick();
    nchk++;
    if (ftw_ready !== 1'b1) begin
      nerr++; $display("FAIL reset_ready got=%b exp=1", ftw_ready);
    end
  endtask

  task automatic test_ftw_load;
    ftw_data = 32'h0020_0000; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    nchk++;
    if (ftw_ready !== 1'b0) begin nerr++; $display("FAIL ready_drop got=%b exp=0", ftw_ready); end
    tick();
    nchk++;
    if (ftw_ready !== 1'b1) begin nerr++; $display("FAIL ready_back got=%b exp=1", ftw_ready); end
    en = 1'b1;
    tick();
    nchk++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL first_edge got=%b exp=0", out_valid); end
    for (int k = 0; k < 9; k++) begin
      tick();
      nchk++;
      if ({out_valid, Address} !== {1'b1, 11'(4 * k)}) begin
        nerr++;
        $display("FAIL addr_ramp k=%0d got=%b/%0d exp=1/%0d", k, out_valid, Address, 4 * k);
      end
    end
    en = 1'b0;
    repeat (2) tick();
    nchk++;
    if ({out_valid, Address} !== {1'b0, 11'd36}) begin
      nerr++; $display("FAIL idle_last got=%b/%0d exp=0/36", out_valid, Address);
    end
    repeat (3) tick();
    nchk++;
    if ({out_valid, Address} !== {1'b0, 11'd36}) begin
      nerr++; $display("FAIL idle_hold got=%b/%0d exp=0/36", out_valid, Address);
    end
    drain("drain_load");
  endtask

  task automatic test_quadrants;
    int n = 0;
    load_ftw(32'h4000_0000);
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid === 1'b1 && n < 8) begin
        nchk++;
        if ({out1, out2, Address, wrap} !== {2'(n % 4), (n % 2 == 1) ? 11'd2047 : 11'd0, n % 4 == 3}) begin
          nerr++;
          $display("FAIL quadrant n=%0d got=%b%b/%0d/%b", n, out1, out2, Address, wrap);
        end
        n++;
      end
    end
    nchk++;
    if (n != 8) begin nerr++; $display("FAIL quad_count got=%0d exp=8", n); end
    drain("drain_quad");
  endtask

  task automatic test_phase_continuous;
    int n = 0;
    logic [10:0] r;
    logic [12:0] top, etop;
    logic ew, er;
    load_ftw(32'h1000_0000);
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c <= 20) begin
        er = !(c >= 6 && c <= 15);
        nchk++;
        if (ftw_ready !== er) begin
          nerr++; $display("FAIL cont_ready c=%0d got=%b exp=%b", c, ftw_ready, er);
        end
      end
      if (out_valid === 1'b1 && n < 31) begin
        r = out2 ? ~Address : Address;
        top = {out1, out2, r};
        etop = (n < 16) ? 13'(n * 512) : 13'(((n - 16) * 1024) % 8192);
        ew = (n == 15) || (n >= 16 && (n - 16) % 8 == 7);
        nchk++;
        if ({top, wrap} !== {etop, ew}) begin
          nerr++;
          $display("FAIL cont_phase n=%0d got=%0d/%b exp=%0d/%b", n, top, wrap, etop, ew);
        end
        n++;
      end
      if (c == 5) begin ftw_data = 32'h2000_0000; ftw_valid = 1'b1; end
      if (c == 6) ftw_valid = 1'b0;
    end
    drain("drain_cont");
  endtask

  task automatic test_pow;
    load_ftw(32'h0);
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    en = 1'b1;
    repeat (3) tick();
    nchk++;
    if ({out_valid, out1, Address} !== {2'b10, 11'd0}) begin
      nerr++; $display("FAIL pow_before got=%b%b/%0d exp=10/0", out_valid, out1, Address);
    end
    pow_data = 32'h8000_0000; pow_load = 1'b1;
    tick();
    pow_load = 1'b0;
    tick();
    nchk++;
    if (out1 !== 1'b0) begin nerr++; $display("FAIL pow_latency got=%b exp=0", out1); end
    tick();
    nchk++;
    if ({out1, out2, Address} !== {2'b10, 11'd0}) begin
      nerr++; $display("FAIL pow_flip got=%b%b/%0d exp=10/0", out1, out2, Address);
    end
    pow_data = 32'h0; pow_load = 1'b1;
    tick();
    pow_load = 1'b0;
    repeat (3) tick();
    drain("drain_pow");
  endtask

  task automatic test_sync_clr;
    load_ftw(32'h1000_0000);
    en = 1'b1;
    repeat (4) tick();
    ftw_data = 32'h3000_0000; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    nchk++;
    if (ftw_ready !== 1'b0) begin nerr++; $display("FAIL clr_pending got=%b exp=0", ftw_ready); end
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    nchk++;
    if (ftw_ready !== 1'b1) begin nerr++; $display("FAIL clr_apply got=%b exp=1", ftw_ready); end
    tick();
    nchk++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL clr_gap got=%b exp=0", out_valid); end
    tick();
    nchk++;
    if ({out_valid, out1, out2, Address} !== {3'b100, 11'd0}) begin
      nerr++; $display("FAIL clr_zero got=%b%b%b/%0d exp=100/0", out_valid, out1, out2, Address);
    end
    tick();
    nchk++;
    if ({out_valid, Address} !== {1'b1, 11'd1536}) begin
      nerr++; $display("FAIL clr_step got=%b/%0d exp=1/1536", out_valid, Address);
    end
    drain("drain_clr");
  endtask

  task automatic test_reset_mid;
    int nv = 0;
    load_ftw(32'h1000_0000);
    en = 1'b1;
    repeat (5) tick();
    ftw_data = 32'h2000_0000; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    #2 RESETn = 1'b0;
    #1;
    nchk++;
    if ({Address, out1, out2, frac, out_valid, wrap, ftw_ready} !== 35'd0) begin
      nerr++;
      $display("FAIL rst_async got=%h exp=0", {Address, out1, out2, frac, out_valid, wrap, ftw_ready});
    end
    tick();
    RESETn = 1'b1;
    tick();
    nchk++;
    if (ftw_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready got=%b exp=1", ftw_ready); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        nv++;
        nchk++;
        if ({Address, out1, out2, frac, wrap} !== 33'd0) begin
          nerr++;
          $display("FAIL rst_zero_ftw got=%h exp=0", {Address, out1, out2, frac, wrap});
        end
      end
    end
    nchk++;
    if (nv < 4) begin nerr++; $display("FAIL rst_valid_count got=%0d exp>=4", nv); end
    drain("drain_rst");
  endtask

  initial begin
    test_reset();
    test_ftw_load();
    test_quadrants();
    test_phase_continuous();
    test_pow();
    test_sync_clr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
